// File: rtl/uart_tx_fifo_drain.sv
// Transmit-side FIFO drain: pops bytes from the TX FIFO and serialises them
// as 8N1 frames (start 0, data LSB first, stop 1) onto a registered txd_o.
//
// state | meaning
// IDLE  | line high, waiting for enable_i and a non-empty FIFO
// START | driving the start bit (0) for CLK_DIV cycles
// DATA  | driving shreg[0], shifting right at each bit-period end
// STOP  | driving the stop bit (1); final cycle may pop the next byte
module uart_tx_fifo_drain #(
    parameter int CLK_DIV    = 16,
    parameter int DIV_WIDTH  = 16,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  enable_i,
    input  logic                  fifo_empty_i,
    input  logic [DATA_WIDTH-1:0] fifo_data_i,
    output logic                  fifo_ren_o,
    output logic                  txd_o,
    output logic                  busy_o
);

    localparam int BIT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [DIV_WIDTH-1:0] CNT_LAST = DIV_WIDTH'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0]     BIT_LAST = BIT_W'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t                state_q, state_d;
    logic [DIV_WIDTH-1:0]  cnt_q, cnt_d;
    logic [BIT_W-1:0]      bit_q, bit_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic                  txd_q, txd_d;
    logic                  busy_q, busy_d;
    logic                  cnt_last;
    logic                  can_pop;
    logic                  pop;

    assign cnt_last = (cnt_q == CNT_LAST);
    // Reset gates the pop so the FIFO never loses a byte to a cycle we discard.
    assign can_pop  = enable_i && !fifo_empty_i && !rst_i;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + DIV_WIDTH'(1);
        bit_d   = bit_q;
        shreg_d = shreg_q;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (can_pop) begin
                    pop     = 1'b1;
                    shreg_d = fifo_data_i;
                    bit_d   = '0;
                    state_d = START;
                end
            end
            START: begin
                if (cnt_last) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (cnt_last) begin
                    cnt_d   = '0;
                    shreg_d = shreg_q >> 1;
                    if (bit_q == BIT_LAST) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
            STOP: begin
                if (cnt_last) begin
                    cnt_d = '0;
                    if (can_pop) begin
                        pop     = 1'b1;
                        shreg_d = fifo_data_i;
                        bit_d   = '0;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // Line level is derived from the next state so txd_o and busy_o move together.
    always_comb begin
        txd_d  = 1'b1;
        busy_d = (state_d != IDLE);
        unique case (state_d)
            START:   txd_d = 1'b0;
            DATA:    txd_d = shreg_d[0];
            default: txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            txd_q   <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            txd_q   <= txd_d;
            busy_q  <= busy_d;
        end
    end

    assign fifo_ren_o = pop;
    assign txd_o      = txd_q;
    assign busy_o     = busy_q;

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Bench for uart_tx_fifo_drain at CLK_DIV=4: FIFO model, frame decoder and
// scoreboard of expected 10-bit frames {stop, data, start}.
module tb_uart_tx_fifo_drain;

    localparam int CDIV = 4;
    localparam int FLEN = 10 * CDIV;

    logic       clk_i;
    logic       rst_i;
    logic       enable_i;
    logic       fifo_empty_i;
    logic [7:0] fifo_data_i;
    logic       fifo_ren_o;
    logic       txd_o;
    logic       busy_o;

    uart_tx_fifo_drain #(.CLK_DIV(CDIV), .DIV_WIDTH(16), .DATA_WIDTH(8)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .enable_i     (enable_i),
        .fifo_empty_i (fifo_empty_i),
        .fifo_data_i  (fifo_data_i),
        .fifo_ren_o   (fifo_ren_o),
        .txd_o        (txd_o),
        .busy_o       (busy_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;
    } vec_t;

    int n_asserts = 0;
    int n_fail    = 0;
    int cyc       = 0;

    logic [7:0] fifo_q[$];
    logic [9:0] exp_q[$];
    int         ren_times[$];

    logic ren_s, txd_s, busy_s, prev_ren;
    int   busy_run, last_busy_run;

    logic       dec_active;
    int         dec_cnt, dec_start, dec_end, dec_gap, frames_done;
    logic [9:0] dec_bits;
    logic       dec_glitch;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_asserts++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void refresh();
        fifo_empty_i = (fifo_q.size() == 0);
        fifo_data_i  = fifo_empty_i ? 8'h00 : fifo_q[0];
    endfunction

    task automatic push_byte(input logic [7:0] b, input logic [9:0] frame);
        fifo_q.push_back(b);
        exp_q.push_back(frame);
        refresh();
    endtask

    task automatic monitor();
        logic [9:0] e;
        ren_s  = fifo_ren_o;
        txd_s  = txd_o;
        busy_s = busy_o;
        n_asserts++;
        if (ren_s && (fifo_empty_i || rst_i)) begin
            n_fail++;
            $display("FAIL ren_guard: ren=%0b empty=%0b rst=%0b", ren_s, fifo_empty_i, rst_i);
        end
        n_asserts++;
        if (ren_s && prev_ren) begin
            n_fail++;
            $display("FAIL ren_double: ren high two cycles at cycle %0d", cyc);
        end
        prev_ren = ren_s;
        if (ren_s) ren_times.push_back(cyc);
        if (busy_s === 1'b1) busy_run++;
        else begin
            if (busy_run > 0) last_busy_run = busy_run;
            busy_run = 0;
        end
        if (rst_i) begin
            dec_active = 1'b0;
        end else begin
            if (!dec_active && txd_s === 1'b0) begin
                dec_active = 1'b1;
                dec_cnt    = 0;
                dec_glitch = 1'b0;
                dec_start  = cyc;
                dec_gap    = cyc - dec_end;
            end
            if (dec_active) begin
                if (dec_cnt % CDIV == 0) dec_bits[dec_cnt / CDIV] = txd_s;
                else if (txd_s !== dec_bits[dec_cnt / CDIV]) dec_glitch = 1'b1;
                if (busy_s !== 1'b1) dec_glitch = 1'b1;
                dec_cnt++;
                if (dec_cnt == FLEN) begin
                    dec_active = 1'b0;
                    dec_end    = cyc;
                    frames_done++;
                    e = (exp_q.size() > 0) ? exp_q.pop_front() : 10'h000;
                    check("frame_bits", 32'(dec_bits), 32'(e));
                    check("frame_shape", 32'(dec_glitch), 32'd0);
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge clk_i);
        cyc++;
        monitor();
        @(posedge clk_i);
        #1;
        if (ren_s && fifo_q.size() > 0) void'(fifo_q.pop_front());
        refresh();
    endtask

    task automatic wait_decoded(input int n, input int max);
        int target;
        int k;
        target = frames_done + n;
        k = 0;
        while (frames_done < target && k < max) begin
            tick();
            k++;
        end
        check("decode_timeout", 32'(frames_done >= target), 32'd1);
    endtask

    task automatic wait_ren(input int max);
        int target;
        int k;
        target = ren_times.size() + 1;
        k = 0;
        while (ren_times.size() < target && k < max) begin
            tick();
            k++;
        end
        check("ren_timeout", 32'(ren_times.size() >= target), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[4];
        int   i0, bad_txd, bad_busy;

        vecs[0] = '{data: 8'h55, frame: 10'h2AA};
        vecs[1] = '{data: 8'h00, frame: 10'h200};
        vecs[2] = '{data: 8'hFF, frame: 10'h3FE};
        vecs[3] = '{data: 8'h81, frame: 10'h302};

        prev_ren = 1'b0; busy_run = 0; last_busy_run = 0;
        dec_active = 1'b0; dec_cnt = 0; dec_start = 0; dec_end = 0;
        dec_gap = 0; frames_done = 0; dec_bits = '0; dec_glitch = 1'b0;

        // Reset with a non-empty FIFO
        rst_i = 1'b1;
        enable_i = 1'b0;
        fifo_q.push_back(8'h11);
        refresh();
        tick();
        for (int k = 0; k < 2; k++) begin
            tick();
            check("rst_txd", 32'(txd_s), 32'd1);
            check("rst_ren", 32'(ren_s), 32'd0);
            check("rst_busy", 32'(busy_s), 32'd0);
        end
        rst_i = 1'b0;
        tick();
        check("rel_txd", 32'(txd_s), 32'd1);
        check("rel_ren", 32'(ren_s), 32'd0);
        check("rel_busy", 32'(busy_s), 32'd0);
        fifo_q.delete();
        refresh();
        tick();

        // Table-driven single frames
        enable_i = 1'b1;
        foreach (vecs[v]) begin
            i0 = ren_times.size();
            push_byte(vecs[v].data, vecs[v].frame);
            wait_decoded(1, 200);
            for (int k = 0; k < 5; k++) tick();
            check("single_pops", 32'(ren_times.size() - i0), 32'd1);
            if (ren_times.size() > i0)
                check("start_latency", 32'(dec_start - ren_times[i0]), 32'd1);
            check("single_busy_len", 32'(last_busy_run), 32'(FLEN));
            check("single_idle_busy", 32'(busy_s), 32'd0);
            check("single_idle_txd", 32'(txd_s), 32'd1);
        end

        // Back-to-back frames
        i0 = ren_times.size();
        push_byte(8'hA5, 10'h34A);
        push_byte(8'h3C, 10'h278);
        wait_decoded(2, 300);
        for (int k = 0; k < 5; k++) tick();
        check("b2b_pops", 32'(ren_times.size() - i0), 32'd2);
        if (ren_times.size() >= i0 + 2)
            check("b2b_ren_spacing", 32'(ren_times[i0+1] - ren_times[i0]), 32'(FLEN));
        check("b2b_gap", 32'(dec_gap), 32'd1);
        check("b2b_busy_len", 32'(last_busy_run), 32'(2 * FLEN));

        // Empty FIFO with enable held
        i0 = ren_times.size();
        bad_txd = 0;
        bad_busy = 0;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (txd_s !== 1'b1) bad_txd++;
            if (busy_s !== 1'b0) bad_busy++;
        end
        check("empty_pops", 32'(ren_times.size() - i0), 32'd0);
        check("empty_txd", 32'(bad_txd), 32'd0);
        check("empty_busy", 32'(bad_busy), 32'd0);

        // enable_i dropped mid-frame with two bytes queued
        i0 = ren_times.size();
        push_byte(8'h0F, 10'h21E);
        push_byte(8'h21, {1'b1, 8'h21, 1'b0});
        push_byte(8'h42, {1'b1, 8'h42, 1'b0});
        wait_ren(20);
        for (int k = 0; k < 9; k++) tick();
        enable_i = 1'b0;
        wait_decoded(1, 100);
        for (int k = 0; k < 60; k++) tick();
        check("en_drop_pops", 32'(ren_times.size() - i0), 32'd1);
        check("en_drop_busy", 32'(busy_s), 32'd0);
        check("en_drop_fifo", 32'(fifo_q.size()), 32'd2);
        enable_i = 1'b1;
        wait_decoded(2, 300);
        for (int k = 0; k < 5; k++) tick();
        check("en_resume_pops", 32'(ren_times.size() - i0), 32'd3);

        // Reset mid-frame
        i0 = ren_times.size();
        push_byte(8'h99, {1'b1, 8'h99, 1'b0});
        push_byte(8'hC3, {1'b1, 8'hC3, 1'b0});
        wait_ren(20);
        for (int k = 0; k < 17; k++) tick();
        rst_i = 1'b1;
        void'(exp_q.pop_front());
        tick();
        rst_i = 1'b0;
        tick();
        check("abort_txd", 32'(txd_s), 32'd1);
        check("abort_busy", 32'(busy_s), 32'd0);
        wait_decoded(1, 200);
        for (int k = 0; k < 5; k++) tick();
        check("abort_pops", 32'(ren_times.size() - i0), 32'd2);
        check("abort_fifo", 32'(fifo_q.size()), 32'd0);
        check("abort_busy_len", 32'(last_busy_run), 32'(FLEN));

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
